// File: rtl/ahb_bus_matrix_pkg.sv
// Shared AHB definitions for the bus-matrix: transfer/burst codes,
// the "no input granted" index and a beats-per-burst helper.
package ahb_bus_matrix_pkg;

    localparam int         NUM_IN   = 3;
    localparam logic [1:0] NONE_IDX = 2'b11;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    // Fixed-length bursts return their beat count; SINGLE/INCR count as 1.
    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
            default:                      burst_beats = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_bus_matrix_rr_pick.sv
// Combinational 3-way round-robin picker: the search starts at the input
// after last and wraps, so last itself has lowest priority.
module ahb_bus_matrix_rr_pick #(
    parameter logic [1:0] NONE_IDX = 2'b11
) (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       none
);

    logic [1:0] p0, p1, p2;

    always_comb begin
        case (last)
            2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase
    end

    always_comb begin
        idx  = NONE_IDX;
        none = 1'b1;
        if (req[p0]) begin
            idx  = p0;
            none = 1'b0;
        end else if (req[p1]) begin
            idx  = p1;
            none = 1'b0;
        end else if (req[p2]) begin
            idx  = p2;
            none = 1'b0;
        end
    end

endmodule

// File: rtl/ahb_bus_matrix_arbiter_mi.sv
// Round-robin arbiter for one bus-matrix output port shared by three input
// stages; holds the grant across fixed bursts, INCR bursts and locked sequences.
module ahb_bus_matrix_arbiter_mi
    import ahb_bus_matrix_pkg::*;
#(
    parameter int         NUM_IN   = 3,
    parameter logic [1:0] NONE_IDX = ahb_bus_matrix_pkg::NONE_IDX
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [NUM_IN-1:0]     req_vec,
    input  logic [2*NUM_IN-1:0]   trans_vec,
    input  logic [3*NUM_IN-1:0]   burst_vec,
    input  logic [NUM_IN-1:0]     mastlock_vec,
    input  logic                  HREADYM,
    output logic [1:0]            addr_in_port,
    output logic                  no_port,
    output logic [NUM_IN-1:0]     active_vec,
    output logic [1:0]            data_in_port,
    output logic                  data_valid
);

    logic [1:0] addr_q, last_q, data_q, addr_next;
    logic       nop_q, dval_q, nop_next;
    logic [3:0] cnt_q, cnt_next;
    logic [2:0] eff_req;
    logic [1:0] pick_idx;
    logic       pick_none;
    htrans_t    g_trans;
    logic [2:0] g_burst;
    logic       g_lock, g_req;
    logic       lock_hold, burst_hold, hold;

    assign eff_req = req_vec & {trans_vec[5], trans_vec[3], trans_vec[1]};

    ahb_bus_matrix_rr_pick #(.NONE_IDX(NONE_IDX)) u_pick (
        .req  (eff_req),
        .last (last_q),
        .idx  (pick_idx),
        .none (pick_none)
    );

    always_comb begin
        g_trans = HTRANS_IDLE;
        g_burst = HBURST_SINGLE;
        g_lock  = 1'b0;
        g_req   = 1'b0;
        case (addr_q)
            2'd0: begin g_trans = htrans_t'(trans_vec[1:0]); g_burst = burst_vec[2:0];
                        g_lock = mastlock_vec[0]; g_req = req_vec[0]; end
            2'd1: begin g_trans = htrans_t'(trans_vec[3:2]); g_burst = burst_vec[5:3];
                        g_lock = mastlock_vec[1]; g_req = req_vec[1]; end
            2'd2: begin g_trans = htrans_t'(trans_vec[5:4]); g_burst = burst_vec[8:6];
                        g_lock = mastlock_vec[2]; g_req = req_vec[2]; end
            default: ;
        endcase
    end

    // Remaining SEQ beats after the transfer accepted this cycle.
    always_comb begin
        cnt_next = cnt_q;
        if (HREADYM && !nop_q) begin
            case (g_trans)
                HTRANS_NONSEQ: cnt_next = 4'(burst_beats(g_burst) - 5'd1);
                HTRANS_IDLE:   cnt_next = 4'd0;
                HTRANS_SEQ:    if (cnt_q != 4'd0) cnt_next = cnt_q - 4'd1;
                default:       ;
            endcase
        end
    end

    // Looking at the post-beat count lets the grant move on the final beat's edge.
    assign lock_hold  = !nop_q && g_lock && g_req;
    assign burst_hold = !nop_q && ((cnt_next != 4'd0) ||
                        (g_burst == HBURST_INCR &&
                         (g_trans == HTRANS_SEQ || g_trans == HTRANS_BUSY)));
    assign hold       = lock_hold || burst_hold;

    always_comb begin
        addr_next = addr_q;
        nop_next  = nop_q;
        if (!hold) begin
            nop_next = pick_none;
            if (!pick_none) addr_next = pick_idx;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q <= 2'd0;
            nop_q  <= 1'b1;
            last_q <= 2'd2;
            cnt_q  <= 4'd0;
            data_q <= 2'd0;
            dval_q <= 1'b0;
        end else if (HREADYM) begin
            addr_q <= addr_next;
            nop_q  <= nop_next;
            cnt_q  <= cnt_next;
            data_q <= addr_q;
            dval_q <= !nop_q && g_trans[1];
            if (!hold && !pick_none) last_q <= pick_idx;
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = nop_q;
    assign data_in_port = data_q;
    assign data_valid   = dval_q;

    always_comb begin
        active_vec = '0;
        if (!nop_q) begin
            case (addr_q)
                2'd0:    active_vec[0] = 1'b1;
                2'd1:    active_vec[1] = 1'b1;
                2'd2:    active_vec[2] = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_bus_matrix_arbiter_mi.sv
// Directed table-driven bench for the MI arbiter plus hand-written
// reset/latency sequences.
module tb_ahb_bus_matrix_arbiter_mi;

    localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10, TS = 2'b11;
    localparam logic [2:0] SG = 3'd0, I4 = 3'd3, I8 = 3'd5;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic [2:0] req_vec = '0;
    logic [5:0] trans_vec = '0;
    logic [8:0] burst_vec = '0;
    logic [2:0] mastlock_vec = '0;
    logic       HREADYM = 1'b1;
    logic [1:0] addr_in_port, data_in_port;
    logic       no_port, data_valid;
    logic [2:0] active_vec;

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    ahb_bus_matrix_arbiter_mi dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_vec      (req_vec),
        .trans_vec    (trans_vec),
        .burst_vec    (burst_vec),
        .mastlock_vec (mastlock_vec),
        .HREADYM      (HREADYM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .active_vec   (active_vec),
        .data_in_port (data_in_port),
        .data_valid   (data_valid)
    );

    typedef struct {
        bit         rst;
        logic [2:0] req;
        logic [5:0] trans;
        logic [8:0] burst;
        logic [2:0] lock;
        logic       hr;
        logic [1:0] addr;
        logic       nop;
        logic [2:0] act;
        logic [1:0] dport;
        logic       dval;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, logic [2:0] req,
                                logic [1:0] t2, logic [1:0] t1, logic [1:0] t0,
                                logic [2:0] b2, logic [2:0] b1, logic [2:0] b0,
                                logic [2:0] lock, logic hr,
                                logic [1:0] addr, logic nop, logic [2:0] act,
                                logic [1:0] dport, logic dval);
        vec_t v;
        v.rst = rst; v.req = req; v.trans = {t2, t1, t0}; v.burst = {b2, b1, b0};
        v.lock = lock; v.hr = hr; v.addr = addr; v.nop = nop; v.act = act;
        v.dport = dport; v.dval = dval;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", nm, idx, got, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [1:0] a, input logic n,
                           input logic [2:0] act, input logic [1:0] dp, input logic dv);
        chk("addr_in_port", idx, 4'(addr_in_port), 4'(a));
        chk("no_port",      idx, 4'(no_port),      4'(n));
        chk("active_vec",   idx, 4'(active_vec),   4'(act));
        chk("data_in_port", idx, 4'(data_in_port), 4'(dp));
        chk("data_valid",   idx, 4'(data_valid),   4'(dv));
    endtask

    task automatic idle_inputs();
        req_vec = '0; trans_vec = '0; burst_vec = '0; mastlock_vec = '0; HREADYM = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
    endtask

    initial begin
        // S1 single NONSEQ from reset
        vecs.push_back(mk(1, 3'b010, TI, TN, TI, SG, SG, SG, 3'b000, 1, 2'd1, 0, 3'b010, 2'd0, 0));
        vecs.push_back(mk(0, 3'b010, TI, TN, TI, SG, SG, SG, 3'b000, 1, 2'd1, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(0, 3'b000, TI, TI, TI, SG, SG, SG, 3'b000, 1, 2'd1, 1, 3'b000, 2'd1, 0));
        // rotation with all three requesting
        vecs.push_back(mk(1, 3'b111, TN, TN, TN, SG, SG, SG, 3'b000, 1, 2'd0, 0, 3'b001, 2'd0, 0));
        vecs.push_back(mk(0, 3'b111, TN, TN, TN, SG, SG, SG, 3'b000, 1, 2'd1, 0, 3'b010, 2'd0, 1));
        vecs.push_back(mk(0, 3'b111, TN, TN, TN, SG, SG, SG, 3'b000, 1, 2'd2, 0, 3'b100, 2'd1, 1));
        vecs.push_back(mk(0, 3'b111, TN, TN, TN, SG, SG, SG, 3'b000, 1, 2'd0, 0, 3'b001, 2'd2, 1));
        // S2 INCR4 with one BUSY, S0 waiting
        vecs.push_back(mk(1, 3'b100, TN, TI, TI, I4, SG, SG, 3'b000, 1, 2'd2, 0, 3'b100, 2'd0, 0));
        vecs.push_back(mk(0, 3'b101, TN, TI, TN, I4, SG, SG, 3'b000, 1, 2'd2, 0, 3'b100, 2'd2, 1));
        vecs.push_back(mk(0, 3'b101, TS, TI, TN, I4, SG, SG, 3'b000, 1, 2'd2, 0, 3'b100, 2'd2, 1));
        vecs.push_back(mk(0, 3'b101, TB, TI, TN, I4, SG, SG, 3'b000, 1, 2'd2, 0, 3'b100, 2'd2, 0));
        vecs.push_back(mk(0, 3'b101, TS, TI, TN, I4, SG, SG, 3'b000, 1, 2'd2, 0, 3'b100, 2'd2, 1));
        vecs.push_back(mk(0, 3'b101, TS, TI, TN, I4, SG, SG, 3'b000, 1, 2'd0, 0, 3'b001, 2'd2, 1));
        // S1 INCR8 terminated by IDLE after beat 3, S2 waiting
        vecs.push_back(mk(1, 3'b010, TI, TN, TI, SG, I8, SG, 3'b000, 1, 2'd1, 0, 3'b010, 2'd0, 0));
        vecs.push_back(mk(0, 3'b110, TN, TN, TI, SG, I8, SG, 3'b000, 1, 2'd1, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(0, 3'b110, TN, TS, TI, SG, I8, SG, 3'b000, 1, 2'd1, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(0, 3'b110, TN, TS, TI, SG, I8, SG, 3'b000, 1, 2'd1, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(0, 3'b110, TN, TI, TI, SG, I8, SG, 3'b000, 1, 2'd2, 0, 3'b100, 2'd1, 0));
        // S0 locked singles, S1 waiting
        vecs.push_back(mk(1, 3'b011, TI, TN, TN, SG, SG, SG, 3'b001, 1, 2'd0, 0, 3'b001, 2'd0, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 3'b011, TI, TN, TN, SG, SG, SG, 3'b001, 1, 2'd0, 0, 3'b001, 2'd0, 1));
        vecs.push_back(mk(0, 3'b010, TI, TN, TI, SG, SG, SG, 3'b000, 1, 2'd1, 0, 3'b010, 2'd0, 0));
        // request during wait state, granted once HREADYM returns
        vecs.push_back(mk(1, 3'b001, TI, TI, TN, SG, SG, SG, 3'b000, 0, 2'd0, 1, 3'b000, 2'd0, 0));
        vecs.push_back(mk(0, 3'b001, TI, TI, TN, SG, SG, SG, 3'b000, 1, 2'd0, 0, 3'b001, 2'd0, 0));
        // S2 INCR4 frozen by 5 wait states
        vecs.push_back(mk(1, 3'b100, TN, TI, TI, I4, SG, SG, 3'b000, 1, 2'd2, 0, 3'b100, 2'd0, 0));
        vecs.push_back(mk(0, 3'b101, TN, TI, TN, I4, SG, SG, 3'b000, 1, 2'd2, 0, 3'b100, 2'd2, 1));
        vecs.push_back(mk(0, 3'b101, TS, TI, TN, I4, SG, SG, 3'b000, 1, 2'd2, 0, 3'b100, 2'd2, 1));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 3'b101, TS, TI, TN, I4, SG, SG, 3'b000, 0, 2'd2, 0, 3'b100, 2'd2, 1));

        do_reset();
        chk_all(-1, 2'd0, 1'b1, 3'b000, 2'd0, 1'b0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            req_vec      = vecs[i].req;
            trans_vec    = vecs[i].trans;
            burst_vec    = vecs[i].burst;
            mastlock_vec = vecs[i].lock;
            HREADYM      = vecs[i].hr;
            @(posedge HCLK);
            #1;
            chk_all(i, vecs[i].addr, vecs[i].nop, vecs[i].act, vecs[i].dport, vecs[i].dval);
        end

        // asynchronous reset in the middle of the wait-stated burst
        #2 HRESETn = 1'b0;
        #1 chk_all(100, 2'd0, 1'b1, 3'b000, 2'd0, 1'b0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        idle_inputs();
        req_vec = 3'b010; trans_vec = {TI, TN, TI};
        #1 chk_all(101, 2'd0, 1'b1, 3'b000, 2'd0, 1'b0);
        @(posedge HCLK);
        #1 chk_all(102, 2'd1, 1'b0, 3'b010, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_bus_matrix_arbiter_mi.md
# ahb_bus_matrix_arbiter_mi

Round-robin arbiter for one bus-matrix output port (MI) shared by three input stages (S0..S2). Each input stage's decoder asserts a per-MI select. The arbiter picks one input for the address phase and holds that grant across fixed-length bursts and locked sequences. It returns the per-input `active` flag to each decoder and tracks the data-phase owner for response routing. One instance sits in front of each output stage.

## Interface
Parameters:
- `NUM_IN`, 3, number of input stages; fixed at 3 for this release, 2-bit port index.
- `NONE_IDX`, 2'b11, index value reserved for "no input granted".

Ports (reset: HRESETn, asynchronous, active-low; clock: HCLK):
- `HCLK` in 1: AHB clock.
- `HRESETn` in 1: asynchronous active-low reset.
- `req_vec` in 3: bit i = input stage i selects this MI (`sel_decN` from decoder Si).
- `trans_vec` in 6: HTRANS of input i at bits [2i+1:2i].
- `burst_vec` in 9: HBURST of input i at bits [3i+2:3i].
- `mastlock_vec` in 3: HMASTLOCK per input.
- `HREADYM` in 1: HREADY of the output port (transfer completes this cycle).
- `addr_in_port` out 2: registered address-phase grant index.
- `no_port` out 1: registered; 1 = no input granted.
- `active_vec` out 3: bit i = (`addr_in_port`==i) & ~`no_port`; drives `active_decN` of decoder Si.
- `data_in_port` out 2: registered data-phase owner.
- `data_valid` out 1: registered; 1 = the data phase in progress belongs to a real (NONSEQ/SEQ) transfer.

## Operation
- Effective request: `eff_req[i]` = `req_vec[i]` & `trans_vec[2i+1]`. An IDLE or BUSY select does not win arbitration.
- Hold: `hold` = `lock_hold` | `burst_hold`. While `hold`=1 the grant does not change.
  - `lock_hold` = `mastlock` of the granted input & `req_vec` of the granted input.
  - `burst_hold` = `beat_cnt`≠0, or (granted HBURST=INCR and granted HTRANS ∈ {SEQ, BUSY}).
- Round-robin: with `hold`=0, search `eff_req` starting at `last_grant`+1 mod 3.
  - The first hit becomes `next_grant`.
  - No hit: `next_no_port`=1 and `addr_in_port` retains its value.
  - `last_grant` updates only when a real grant is registered.
- Register update: `addr_in_port`/`no_port` <= next values when `HREADYM`=1; otherwise hold.
- Burst counter (`beat_cnt`, 4 bits):
  - Load: on a NONSEQ from the granted input with `HREADYM`=1 and HBURST ∈ {WRAP4/INCR4}, {WRAP8/INCR8}, {WRAP16/INCR16}, load 3, 7 or 15 respectively.
  - Decrement on each granted SEQ with `HREADYM`=1.
  - BUSY: no change.
  - Early termination: granted input issues IDLE or NONSEQ while `beat_cnt`≠0 → clear to 0 (or reload if the NONSEQ is itself a fixed burst).
- Data phase: when `HREADYM`=1:
  - `data_in_port` <= `addr_in_port`.
  - `data_valid` <= ~`no_port` & granted HTRANS[1].
- Reset values: `addr_in_port`=0, `no_port`=1, `last_grant`=2 (S0 wins first), `beat_cnt`=0, `data_in_port`=0, `data_valid`=0, `active_vec`=0.

## Timing
- Idle MI with `HREADYM`=1: request in cycle n → `active_vec`/`addr_in_port` valid in cycle n+1. Fixed 1-cycle arbitration latency.
- `HREADYM`=0: all registers frozen. A request arriving during a wait state is granted at the first cycle after `HREADYM` returns high.
- Simultaneous requests: exactly one grant per arbitration edge; the others see `active`=0 and are held by their input stage.
- Last beat: the grant may move on the same edge that completes the final beat (`beat_cnt`=0 and granted SEQ accepted). No idle cycle is inserted.
- Mid-operation reset: all state returns to reset values immediately (asynchronous). The next grant follows the normal 1-cycle latency after deassertion.
- `active_vec` is purely combinational from registers; there is no combinational path from `req_vec` to `active_vec`.

## Structure
- Shared package (`ahb_bus_matrix_pkg`) holds:
  - HTRANS codes: IDLE/BUSY/NONSEQ/SEQ.
  - HBURST codes.
  - `NONE_IDX`.
  - A beats-per-burst function.
- Natural sub-module: `ahb_bus_matrix_rr_pick`, a combinational 3-way round-robin priority picker (req, last → idx, none).
- Burst counter and hold logic stay in the top module.

## Test plan
- Reset release, S1 requests NONSEQ SINGLE → `addr_in_port`=1, `active_vec`=3'b010 one cycle later; `data_in_port`=1, `data_valid`=1 the cycle after.
- S0, S1, S2 request continuously with SINGLE transfers, `HREADYM`=1 → grants rotate 0,1,2,0,... one per cycle.
- S2 runs an INCR4 burst while S0 requests → S2 holds for 4 beats; S0 is granted on the edge completing beat 4. With BUSY inserted, the hold stretches accordingly.
- S1 runs an INCR8 burst and issues IDLE after beat 3 while S2 requests → `beat_cnt` clears and S2 is granted next cycle.
- S0 sets `mastlock_vec`[0]=1 across 3 SINGLE transfers while S1 requests → S1 is granted only after S0 drops lock.
- `HREADYM`=0 for 5 cycles mid-burst, then HRESETn asserted for 1 cycle → all outputs freeze during the wait, then return to reset values (`no_port`=1, `active_vec`=0).
